// File: rtl/dedbx_pkg.sv
// Shared types and constants for the iterative bitplane decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state type, mode encodings, default geometry.
package dedbx_pkg;

  localparam int SYM_W_DEF   = 8;
  localparam int NUM_SYM_DEF = 32;

  localparam logic MODE_DBX = 1'b0;  // inverse XOR chain across planes
  localparam logic MODE_BP  = 1'b1;  // plain transpose

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dedbx_row.sv
// Single-plane decode: undo the XOR chain for one bitplane (or pass it through).
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
//
// Ports:
//   plane_i - encoded plane, column 0 at the MSB
//   prev_i  - previously decoded plane (same column layout)
//   mode_i  - MODE_DBX or MODE_BP
//   first_i - high for plane 0, which always passes unchanged
//   dec_o   - decoded plane
module dedbx_row
  import dedbx_pkg::*;
#(
  parameter int NUM_SYM = NUM_SYM_DEF
) (
  input  logic [NUM_SYM-1:0] plane_i,
  input  logic [NUM_SYM-1:0] prev_i,
  input  logic               mode_i,
  input  logic               first_i,
  output logic [NUM_SYM-1:0] dec_o
);

  always_comb begin
    dec_o = plane_i;
    if ((mode_i == MODE_DBX) && !first_i) begin
      // Column 0 (MSB) is never chained; every other column folds in the
      // decoded value of the same column one plane up.
      for (int c = 1; c < NUM_SYM; c++) begin
        dec_o[NUM_SYM-1-c] = plane_i[NUM_SYM-1-c] ^ prev_i[NUM_SYM-1-c];
      end
    end
  end

endmodule

// File: rtl/dedbx_iter.sv
// Iterative bitplane decoder: one plane per cycle, transposed into symbol order.
// Latency: out_valid_o rises SYM_W clock edges after the accepting edge.
// Backpressure: result held in DONE until out_ready_i; no new block accepted until IDLE.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   in_valid_i    - block offered on bpx_i/mode_i; in_ready_o high only in IDLE
//   mode_i        - MODE_DBX (inverse XOR chain) or MODE_BP (transpose only)
//   bpx_i         - SYM_W planes of NUM_SYM bits, plane 0 in the top bits
//   out_valid_o   - diff_o holds a complete decoded block (DONE)
//   out_ready_i   - downstream accepts the block
//   diff_o        - NUM_SYM symbols of SYM_W bits, symbol 0 in the top bits
//   busy_o        - any state other than IDLE
module dedbx_iter
  import dedbx_pkg::*;
#(
  parameter int SYM_W   = SYM_W_DEF,
  parameter int NUM_SYM = NUM_SYM_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       mode_i,
  input  logic [SYM_W*NUM_SYM-1:0]   bpx_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [SYM_W*NUM_SYM-1:0]   diff_o,
  output logic                       busy_o
);

  localparam int TOT_W = SYM_W * NUM_SYM;
  localparam int ROW_W = (SYM_W > 1) ? $clog2(SYM_W) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SYM_W - 1);

  state_e             state_q;
  logic [ROW_W-1:0]   row_q;
  logic [TOT_W-1:0]   data_q;
  logic               mode_q;
  logic [NUM_SYM-1:0] prev_q;
  logic [TOT_W-1:0]   diff_q;
  logic [TOT_W-1:0]   diff_d;

  logic [NUM_SYM-1:0] plane;
  logic [NUM_SYM-1:0] dec;
  logic               first_row;

  assign first_row = (row_q == '0);

  // Plane k lives NUM_SYM*(SYM_W-1-k) bits above the LSB.
  always_comb begin
    plane = data_q[(SYM_W - 1 - int'(row_q)) * NUM_SYM +: NUM_SYM];
  end

  dedbx_row #(
    .NUM_SYM (NUM_SYM)
  ) u_row (
    .plane_i (plane),
    .prev_i  (prev_q),
    .mode_i  (mode_q),
    .first_i (first_row),
    .dec_o   (dec)
  );

  // Transpose write: column j of the current plane becomes bit 'row' of
  // symbol j. Bits of other planes keep whatever they held.
  always_comb begin
    diff_d = diff_q;
    for (int j = 0; j < NUM_SYM; j++) begin
      diff_d[TOT_W - 1 - SYM_W*j - int'(row_q)] = dec[NUM_SYM-1-j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      data_q  <= '0;
      mode_q  <= MODE_DBX;
      prev_q  <= '0;
      diff_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            data_q  <= bpx_i;
            mode_q  <= mode_i;
            row_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          diff_q <= diff_d;
          prev_q <= dec;
          // Counter parks on the last row rather than wrapping.
          if (row_q == LAST_ROW) begin
            state_q <= DONE;
          end else begin
            row_q <= row_q + ROW_W'(1);
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign diff_o      = diff_q;

endmodule

// File: tb/tb_dedbx_iter.sv
module tb_dedbx_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]   iv   = 3'b000;
  logic [2:0]   md   = 3'b000;
  logic [2:0]   ordy = 3'b111;
  logic [255:0] bpx_drv [3];

  wire [2:0]   ir, ov, bz;
  wire [255:0] d_a;
  wire [31:0]  d_b;
  wire [3:0]   d_c;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Scoreboard: each instance holds at most one block in flight.
  logic [255:0] exp_v [3];
  bit           pend  [3];
  bit           seen  [3];
  bit           hs    [3];
  int           acc_edge [3];

  dedbx_iter u_a (
    .clk(clk), .rst(rst), .in_valid_i(iv[0]), .in_ready_o(ir[0]), .mode_i(md[0]),
    .bpx_i(bpx_drv[0]), .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .diff_o(d_a), .busy_o(bz[0])
  );

  dedbx_iter #(.SYM_W(4), .NUM_SYM(8)) u_b (
    .clk(clk), .rst(rst), .in_valid_i(iv[1]), .in_ready_o(ir[1]), .mode_i(md[1]),
    .bpx_i(bpx_drv[1][31:0]), .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .diff_o(d_b), .busy_o(bz[1])
  );

  dedbx_iter #(.SYM_W(1), .NUM_SYM(4)) u_c (
    .clk(clk), .rst(rst), .in_valid_i(iv[2]), .in_ready_o(ir[2]), .mode_i(md[2]),
    .bpx_i(bpx_drv[2][3:0]), .out_valid_o(ov[2]), .out_ready_i(ordy[2]), .diff_o(d_c), .busy_o(bz[2])
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sw_of(input int d);
    case (d)
      0: return 8;
      1: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int ns_of(input int d);
    case (d)
      0: return 32;
      1: return 8;
      default: return 4;
    endcase
  endfunction

  function automatic logic [255:0] diff_of(input int d);
    case (d)
      0: return d_a;
      1: return {224'b0, d_b};
      default: return {252'b0, d_c};
    endcase
  endfunction

  // Reference: split into planes, undo the chain plane by plane, then
  // scatter plane k / column j into bit k of symbol j.
  function automatic logic [255:0] model(input logic [255:0] b, input logic m,
                                         input int sw, input int ns);
    logic [31:0]  dec [8];
    logic [255:0] r;
    logic         in_b;
    r = '0;
    for (int k = 0; k < sw; k++) begin
      for (int c = 0; c < ns; c++) begin
        in_b = b[ns*(sw-k)-1-c];
        if (m == 1'b1 || k == 0 || c == 0) dec[k][c] = in_b;
        else                               dec[k][c] = in_b ^ dec[k-1][c];
        r[sw*ns - sw*c - 1 - k] = dec[k][c];
      end
    end
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare process: runs on every falling edge for all three instances.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        chk($sformatf("rst_ready_u%0d", d), ir[d], 1);
        chk($sformatf("rst_valid_u%0d", d), ov[d], 0);
        chk($sformatf("rst_busy_u%0d", d),  bz[d], 0);
        chk($sformatf("rst_diff_u%0d", d),  diff_of(d), 0);
        pend[d] = 1'b0;
        hs[d]   = 1'b0;
      end else begin
        if (hs[d]) chk($sformatf("ready_after_hs_u%0d", d), ir[d], 1);
        hs[d] = 1'b0;
        chk($sformatf("ready_vs_busy_u%0d", d), ir[d], !bz[d]);
        if (!pend[d]) begin
          chk($sformatf("spurious_valid_u%0d", d), ov[d], 0);
        end else begin
          if (!seen[d]) begin
            if (ov[d]) begin
              chk($sformatf("latency_u%0d", d), cyc - acc_edge[d], sw_of(d));
              seen[d] = 1'b1;
            end else if (cyc - acc_edge[d] >= sw_of(d)) begin
              chk($sformatf("valid_late_u%0d", d), ov[d], 1);
            end
          end
          if (ov[d]) begin
            chk($sformatf("diff_u%0d", d), diff_of(d), exp_v[d]);
            chk($sformatf("ready_in_done_u%0d", d), ir[d], 0);
            if (ordy[d]) begin
              pend[d] = 1'b0;
              hs[d]   = 1'b1;
            end
          end
        end
        if (iv[d] && ir[d]) begin
          exp_v[d]    = model(bpx_drv[d], md[d], sw_of(d), ns_of(d));
          pend[d]     = 1'b1;
          seen[d]     = 1'b0;
          acc_edge[d] = cyc + 1;
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input int d, input logic [255:0] b, input logic m);
    bpx_drv[d] = b;
    md[d]      = m;
    iv[d]      = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ir[d]) begin
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        return;
      end
    end
    chk($sformatf("send_timeout_u%0d", d), 0, 1);
    iv[d] = 1'b0;
  endtask

  // Returns on the falling edge where out_valid_o is seen.
  task automatic wait_valid(input int d);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ov[d]) return;
    end
    chk($sformatf("valid_timeout_u%0d", d), 0, 1);
  endtask

  task automatic run_block(input int d, input logic [255:0] b, input logic m);
    send(d, b, m);
    wait_valid(d);
    @(posedge clk);
    #1;
  endtask

  logic [255:0] lit;

  initial begin
    for (int d = 0; d < 3; d++) begin
      bpx_drv[d] = '0;
      exp_v[d]   = '0;
      pend[d]    = 1'b0;
      seen[d]    = 1'b0;
      hs[d]      = 1'b0;
      acc_edge[d] = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // DBX, all ones: symbol 0 = FF, others AA.
    send(0, {256{1'b1}}, 1'b0);
    wait_valid(0);
    lit = {8'hFF, {31{8'hAA}}};
    chk("dbx_all_ones", d_a, lit);
    @(posedge clk);
    #1;

    // BP, plane 0 all ones: every symbol 80.
    send(0, {32'hFFFF_FFFF, 224'h0}, 1'b1);
    wait_valid(0);
    lit = {32{8'h80}};
    chk("bp_plane0", d_a, lit);
    @(posedge clk);
    #1;

    // Backpressure in DONE with a stray in_valid pulse.
    ordy[0] = 1'b0;
    send(0, rnd256(), 1'b0);
    wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        iv[0]      = 1'b1;
        md[0]      = 1'b1;
        bpx_drv[0] = rnd256();
      end else begin
        iv[0] = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("bp_hold_valid", ov[0], 1);
      chk("bp_hold_ready", ir[0], 0);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    wait_valid(0);
    @(posedge clk);
    #1;
    chk("bp_ready_back", ir[0], 1);
    repeat (12) @(posedge clk);
    #1;

    // Reset while row 3 is being decoded.
    send(0, rnd256(), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrun_busy", bz[0], 0);
    chk("midrun_ready", ir[0], 1);
    chk("midrun_valid", ov[0], 0);
    chk("midrun_diff", d_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // Random blocks, both modes.
    for (int i = 0; i < 6; i++) run_block(0, rnd256(), 1'($urandom_range(0, 1)));

    // Small geometry, DBX blocks back to back.
    for (int i = 0; i < 20; i++) run_block(1, rnd256(), 1'b0);

    // Single-plane geometry: identity.
    send(2, {252'b0, 4'b1010}, 1'b0);
    wait_valid(2);
    chk("sw1_identity", d_c, 4'b1010);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) run_block(2, rnd256(), 1'($urandom_range(0, 1)));

    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dedbx_iter.md
DEDBX_ITER -- requirements
Module: dedbx_iter

Interface
REQ-001 SHALL have parameter SYM_W, default 8: bits per symbol; equals the number of bitplanes.
REQ-002 SHALL have parameter NUM_SYM, default 32: symbols per block; equals bits per bitplane.
REQ-003 SHALL define localparam TOT_W = SYM_W*NUM_SYM.
REQ-004 SHALL have port clk, input, 1: the single clock; all flops on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid_i, input, 1: input block valid.
REQ-007 SHALL have port in_ready_o, output, 1: block can be accepted.
REQ-008 SHALL have port mode_i, input, 1: 0 = DBX (inverse XOR chain), 1 = BP (transpose only); sampled with data.
REQ-009 SHALL have port bpx_i, input, TOT_W: encoded bitplanes.
REQ-010 SHALL have port out_valid_o, output, 1: diff block valid.
REQ-011 SHALL have port out_ready_i, input, 1: downstream accepts.
REQ-012 SHALL have port diff_o, output, TOT_W: decoded symbol block.
REQ-013 SHALL have port busy_o, output, 1: high whenever state is not IDLE.

Function
REQ-014 Plane k (0..SYM_W-1) SHALL occupy bpx_i[NUM_SYM*(SYM_W-k)-1 : NUM_SYM*(SYM_W-1-k)], MSB-first: column c sits at bit NUM_SYM*(SYM_W-k)-1-c.
REQ-015 Symbol j SHALL occupy diff_o[TOT_W-SYM_W*j-1 : TOT_W-SYM_W*(j+1)]; its bit k sits at TOT_W-SYM_W*j-1-k and equals decoded plane k, column j.
REQ-016 DBX decoding: plane 0 SHALL pass unchanged; for k>=1, column 0 SHALL pass unchanged, and columns c>=1 SHALL be decoded as in[k][c] XOR decoded[k-1][c].
REQ-017 BP mode: decoded plane k SHALL equal the input plane k for all k and columns (transpose only).
REQ-018 FSM SHALL have states IDLE, RUN, DONE; in_ready_o = (state==IDLE); out_valid_o = (state==DONE).
REQ-019 IDLE and in_valid_i: SHALL capture bpx_i and mode_i, clear row counter, go to RUN.
REQ-020 RUN SHALL decode exactly one plane per cycle, in order row = 0..SYM_W-1, using the previously decoded plane held in a SYM_W-independent NUM_SYM-bit register.
REQ-021 RUN with row==SYM_W-1 SHALL go to DONE; out_valid_o SHALL assert on the SYM_W-th rising edge after the accepting edge.
REQ-022 DONE SHALL hold diff_o stable until out_ready_i; on out_valid_o&&out_ready_i SHALL go to IDLE; no new block accepted in that same cycle.
REQ-023 in_valid_i SHALL be ignored outside IDLE; bpx_i/mode_i changes during RUN/DONE SHALL not affect the result.
REQ-024 Row counter width SHALL be $clog2(SYM_W) (min 1); it SHALL not wrap past SYM_W-1.
REQ-025 SYM_W=1 SHALL yield a single RUN cycle and identity output.
REQ-026 diff_o bits not yet written in RUN SHALL keep their previous values; only diff_o in DONE is meaningful.

Reset
REQ-027 Asserting rst SHALL immediately force state IDLE, row counter 0, captured data, previous-plane register, and diff_o to 0, regardless of state.
REQ-028 During and after reset: in_ready_o=1, out_valid_o=0, busy_o=0; a block in flight is discarded, and no partial output is presented.

Structure
REQ-029 A shared package dedbx_pkg SHALL hold the FSM state typedef, the mode encodings (MODE_DBX=0, MODE_BP=1), and the default SYM_W/NUM_SYM constants.
REQ-030 The per-row combinational decode (NUM_SYM-bit plane in, previous plane, mode, first-row flag -> decoded plane) SHALL be one sub-module, dedbx_row; the FSM, counter, and transpose write SHALL live in dedbx_iter.

Verification
REQ-031 Defaults, DBX, bpx_i = all-ones -> plane0 = 1s, plane1 col0 = 1 and cols1..31 = 0, alternating thereafter; every symbol = 8'hAA except symbol 0 = 8'hFF; out_valid_o on the 8th edge after accept.
REQ-032 Defaults, BP mode, bpx_i = {32'hFFFFFFFF, 224'h0} -> every symbol = 8'h80.
REQ-033 Backpressure: out_ready_i low for 5 cycles in DONE -> diff_o stable, in_ready_o=0, a second in_valid_i pulse is ignored; completes after out_ready_i=1.
REQ-034 rst asserted mid-RUN (row 3) -> same cycle state IDLE, diff_o=0, out_valid_o never asserts for that block.
REQ-035 SYM_W=4, NUM_SYM=8: random DBX blocks back-to-back vs. golden model -> all match; in_ready_o re-asserts the cycle after each output handshake.
REQ-036 SYM_W=1, NUM_SYM=4, bpx_i=4'b1010 -> diff_o=4'b1010 after 1 RUN cycle.
